// File: rtl/counter_rr_sched_pkg.sv
// Shared types and default sizing for the round-robin counter scheduler.
// Optional wrap reporting is enabled with COUNTER_RR_SCHED_WRAP_EN.
package counter_rr_sched_pkg;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_WIDTH   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

endpackage

// File: rtl/counter_rr_sched_if.sv
// Requester/counter side bundle of the round-robin counter scheduler.
interface counter_rr_sched_if
   import counter_rr_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned WIDTH   = DEF_WIDTH
);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] step_in;
   logic [NUM_REQ-1:0]       gnt;
   logic [WIDTH-1:0]         cnt_step;
   logic [WIDTH-1:0]         count_out;
   logic [NUM_REQ-1:0]       ack;
   logic [WIDTH-1:0]         rsp_count;
   logic                     rsp_wrap;
   logic                     busy;

   // Requesters plus the counter instance.
   modport master (
      output req, step_in, count_out,
      input  gnt, cnt_step, ack, rsp_count, rsp_wrap, busy
   );

   // The scheduler.
   modport slave (
      input  req, step_in, count_out,
      output gnt, cnt_step, ack, rsp_count, rsp_wrap, busy
   );

endinterface

// File: rtl/cnt_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module cnt_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] win_c,
   output logic               valid_c
);

   always_comb begin
      int unsigned idx;
      win_c   = '0;
      valid_c = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_REQ;
         if (!valid_c && req[PTR_W'(idx)]) begin
            win_c[PTR_W'(idx)] = 1'b1;
            valid_c            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler sharing one accumulating counter among NUM_REQ requesters.
// Define COUNTER_RR_SCHED_WRAP_EN to report the modulo wrap on rsp_wrap.
module counter_rr_sched
   import counter_rr_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned WIDTH   = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   counter_rr_sched_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [WIDTH-1:0]     cnt_step_q, cnt_step_d;
   logic [WIDTH-1:0]     rsp_count_q, rsp_count_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 busy_q, busy_d;

   logic [NUM_REQ-1:0]   win_c;
   logic                 valid_c;
   logic [WIDTH-1:0]     win_step_c;
   logic [PTR_W-1:0]     win_ptr_c;
   logic [WIDTH-1:0]     step_arr [NUM_REQ];

   cnt_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req     (bus.req),
      .rr_ptr  (rr_ptr_q),
      .win_c   (win_c),
      .valid_c (valid_c)
   );

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_step
      assign step_arr[i] = bus.step_in[i*WIDTH +: WIDTH];
   end

   // Step of the current winner and the pointer just past it.
   always_comb begin
      win_step_c = '0;
      win_ptr_c  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_c[PTR_W'(i)]) begin
            win_step_c = step_arr[PTR_W'(i)];
            win_ptr_c  = PTR_W'((i + 1) % NUM_REQ);
         end
      end
   end

   // Pre-update count plus issued step; its low bits are the counter's next value.
`ifdef COUNTER_RR_SCHED_WRAP_EN
   logic [WIDTH:0] sum_c;
   logic           rsp_wrap_q;

   assign sum_c = {1'b0, bus.count_out} + {1'b0, cnt_step_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_wrap_q <= 1'b0;
      end else if (state_q == ISSUE) begin
         rsp_wrap_q <= sum_c[WIDTH];
      end
   end

   assign bus.rsp_wrap = rsp_wrap_q;
`else
   logic [WIDTH-1:0] sum_c;

   assign sum_c        = bus.count_out + cnt_step_q;
   assign bus.rsp_wrap = 1'b0;
`endif

   // Next-state and next-output logic; outputs are registered one step ahead.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      ack_d       = '0;
      cnt_step_d  = '0;
      rsp_count_d = rsp_count_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (valid_c) begin
               state_d    = ISSUE;
               gnt_d      = win_c;
               cnt_step_d = win_step_c;
               rr_ptr_d   = win_ptr_c;
            end
         end
         ISSUE: begin
            state_d     = RESP;
            ack_d       = gnt_q;
            rsp_count_d = sum_c[WIDTH-1:0];
         end
         RESP: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         ack_q       <= '0;
         cnt_step_q  <= '0;
         rsp_count_q <= '0;
         rr_ptr_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         ack_q       <= ack_d;
         cnt_step_q  <= cnt_step_d;
         rsp_count_q <= rsp_count_d;
         rr_ptr_q    <= rr_ptr_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.ack       = ack_q;
   assign bus.cnt_step  = cnt_step_q;
   assign bus.rsp_count = rsp_count_q;
   assign bus.busy      = busy_q;

   // The counter may only move during ISSUE, and acks belong to the held grant.
   a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
   a_step_issue: assert property (@(posedge clk) disable iff (reset)
                                  (state_q != ISSUE) |-> (cnt_step_q == '0));
   a_ack_gnt:    assert property (@(posedge clk) disable iff (reset)
                                  (ack_q != '0) |-> (ack_q == gnt_q));

endmodule
